// File: rtl/dma_reg_arbiter.sv
// ---------------------------------------------------------------------------
// dma_reg_arbiter
//
// Shares one register-interface master port (towards the DMA reg-to-AXI
// bridge) among NumReq register-interface requesters. Round-robin selection,
// a single outstanding transfer, and the winner's request fields are latched
// so the bridge sees a stable request for the whole transfer.
//
// Packed record layouts (MSB first):
//   request  : {addr[ADDR_W-1:0], write, wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0], valid}
//   response : {rdata[DATA_W-1:0], error, ready}
// Requester k occupies slice [k*REQ_W +: REQ_W] of req_i and
// [k*RSP_W +: RSP_W] of rsp_o.
//
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   req_i      in   NumReq packed requests from the requesters
//   rsp_o      out  NumReq packed responses to the requesters
//   req_o      out  packed request to the bridge
//   rsp_i      in   packed response from the bridge
//   busy_o     out  transfer in flight (state != IDLE)
//   gnt_idx_o  out  index of the latched winner, meaningful while busy_o
//
// Optional feature (macro DMA_REG_ARB_TIMEOUT_EN):
//   When defined, a busy counter aborts a transfer after TimeoutCycles BUSY
//   cycles without a bridge ready. The requester gets {rdata=0, error=1,
//   ready=1}, and the arbiter then sits in DRAIN, still presenting the
//   latched request, until the bridge finally answers; that late answer is
//   discarded. When undefined, BUSY waits indefinitely.
// ---------------------------------------------------------------------------
module dma_reg_arbiter #(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1024,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    localparam int STRB_W       = DATA_W / 8,
    localparam int REQ_W        = ADDR_W + 1 + DATA_W + STRB_W + 1,
    localparam int RSP_W        = DATA_W + 2,
    localparam int IDX_W        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq*REQ_W-1:0] req_i,
    output logic [NumReq*RSP_W-1:0] rsp_o,
    output logic [REQ_W-1:0]        req_o,
    input  logic [RSP_W-1:0]        rsp_i,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        gnt_idx_o
);

    // Elaboration-time sanity check on the configuration.
    if (NumReq < 2 || TimeoutCycles < 1) begin : g_bad_params
        $error("dma_reg_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
`ifdef DMA_REG_ARB_TIMEOUT_EN
    localparam logic [1:0] DRAIN = 2'd2;
`endif

    // Latched request without its valid bit; valid is derived from the state.
    localparam int LAT_W = REQ_W - 1;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
`ifdef DMA_REG_ARB_TIMEOUT_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] ptr_next;
    logic             bridge_ready;

    assign bridge_ready = rsp_i[0];

    // Round-robin pick: first valid requester at or after the pointer,
    // wrapping NumReq-1 -> 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!arb_found && req_i[((int'(ptr_q) + i) % NumReq) * REQ_W]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((int'(ptr_q) + i) % NumReq);
            end
        end
    end

    // Pointer moves just past the completed winner; only used on completion.
    assign ptr_next = (gnt_q == IDX_W'(NumReq - 1)) ? '0 : gnt_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        lat_d   = lat_q;
`ifdef DMA_REG_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        rsp_o   = '0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d   = arb_idx;
                    lat_d   = req_i[int'(arb_idx) * REQ_W + 1 +: LAT_W];
                    state_d = BUSY;
`ifdef DMA_REG_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            BUSY: begin
                // A ready arriving on the timeout cycle still completes normally.
                if (bridge_ready) begin
                    rsp_o[int'(gnt_q) * RSP_W +: RSP_W] = {rsp_i[RSP_W-1:1], 1'b1};
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
`ifdef DMA_REG_ARB_TIMEOUT_EN
                else if (cnt_q == 32'(TimeoutCycles - 1)) begin
                    rsp_o[int'(gnt_q) * RSP_W +: RSP_W] = {{DATA_W{1'b0}}, 1'b1, 1'b1};
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end

`ifdef DMA_REG_ARB_TIMEOUT_EN
            DRAIN: begin
                // Requester already got its error; the bridge's late answer is dropped.
                if (bridge_ready) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            lat_q   <= '0;
`ifdef DMA_REG_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            lat_q   <= lat_d;
`ifdef DMA_REG_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign req_o     = {lat_q, busy_o};
    assign gnt_idx_o = gnt_q;

`ifndef SYNTHESIS
    // A granted requester must hold valid until it receives ready.
    a_valid_held: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == BUSY) |-> req_i[int'(gnt_q) * REQ_W]
    ) else $error("dma_reg_arbiter: requester %0d dropped valid while granted", gnt_q);
`endif

endmodule

// File: tb/tb_dma_reg_arbiter.sv
module tb_dma_reg_arbiter;

    localparam int NR  = 4;
    localparam int RQW = 70;   // 32 addr + 1 write + 32 wdata + 4 wstrb + 1 valid
    localparam int RSW = 34;   // 32 rdata + 1 error + 1 ready
`ifdef DMA_REG_ARB_TIMEOUT_EN
    localparam int STALL = 5;
`else
    localparam int STALL = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*RQW-1:0] req_i = '0;
    logic [NR*RSW-1:0] rsp_o;
    logic [RQW-1:0]    req_o;
    logic [RSW-1:0]    rsp_i = '0;
    logic              busy;
    logic [1:0]        gnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dma_reg_arbiter #(
        .NumReq(NR),
        .TimeoutCycles(8),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_i(req_i),
        .rsp_o(rsp_o),
        .req_o(req_o),
        .rsp_i(rsp_i),
        .busy_o(busy),
        .gnt_idx_o(gnt)
    );

    function automatic logic [RQW-1:0] mk_req(input logic [31:0] a, input logic w,
                                              input logic [31:0] d, input logic [3:0] s,
                                              input logic v);
        return {a, w, d, s, v};
    endfunction

    function automatic logic [RSW-1:0] mk_rsp(input logic [31:0] d, input logic e, input logic r);
        return {d, e, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [RQW-1:0] v);
        req_i[k*RQW +: RQW] = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_i = '0;
        rsp_i = '0;
        #12;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (req_o !== '0) $display("FAIL reset_req_o: got %h want 0", req_o); else n_pass++;
        n_checks++; if (rsp_o !== '0) $display("FAIL reset_rsp_o: got %h want 0", rsp_o); else n_pass++;
        n_checks++; if (gnt !== 2'd0) $display("FAIL reset_gnt: got %0d want 0", gnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write;
        logic [RQW-1:0]    r;
        logic [NR*RSW-1:0] er;
        r = mk_req(32'h100, 1'b1, 32'hDEAD, 4'hF, 1'b1);
        set_req(0, r);
        #1;
        n_checks++; if (req_o[0] !== 1'b0) $display("FAIL sw_idle_valid: got %0b want 0", req_o[0]); else n_pass++;
        tick();
        n_checks++; if (req_o !== r) $display("FAIL sw_req_o: got %h want %h", req_o, r); else n_pass++;
        n_checks++; if (busy !== 1'b1 || gnt !== 2'd0) $display("FAIL sw_busy_gnt: got %0b/%0d want 1/0", busy, gnt); else n_pass++;
        n_checks++; if (rsp_o !== '0) $display("FAIL sw_rsp_early: got %h want 0", rsp_o); else n_pass++;
        tick();
        tick();
        rsp_i = mk_rsp(32'h0, 1'b0, 1'b1);
        #1;
        er = '0;
        er[0 +: RSW] = mk_rsp(32'h0, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL sw_rsp_ready: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(0, '0);
        rsp_i = '0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL sw_done_idle: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_contention;
        logic [RQW-1:0]    ra, rb;
        logic [NR*RSW-1:0] er;
        do_reset();
        ra = mk_req(32'h200, 1'b0, 32'h0, 4'h0, 1'b1);
        rb = mk_req(32'h300, 1'b0, 32'h0, 4'h0, 1'b1);
        set_req(0, ra);
        set_req(1, rb);
        tick();
        n_checks++; if (gnt !== 2'd0 || req_o !== ra) $display("FAIL ct_first: got gnt %0d req %h want 0 %h", gnt, req_o, ra); else n_pass++;
        rsp_i = mk_rsp(32'h1111, 1'b0, 1'b1);
        #1;
        er = '0;
        er[0 +: RSW] = mk_rsp(32'h1111, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL ct_rsp0: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(0, '0);
        rsp_i = '0;
        #1;
        n_checks++; if (busy !== 1'b0 || req_o[0] !== 1'b0) $display("FAIL ct_bubble: got busy %0b valid %0b want 0 0", busy, req_o[0]); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'd1 || req_o !== rb) $display("FAIL ct_second: got gnt %0d req %h want 1 %h", gnt, req_o, rb); else n_pass++;
        rsp_i = mk_rsp(32'hCAFE, 1'b0, 1'b1);
        #1;
        er = '0;
        er[1*RSW +: RSW] = mk_rsp(32'hCAFE, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL ct_rsp1: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(1, '0);
        rsp_i = '0;
    endtask

    task automatic test_fairness;
        logic [NR*RSW-1:0] er;
        logic [RQW-1:0]    rexp;
        int                e;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, mk_req(32'h1000 + 32'(k*4), 1'b0, 32'h0, 4'h0, 1'b1));
        for (int n = 0; n < 5; n++) begin
            e = n % NR;
            tick();
            rexp = mk_req(32'h1000 + 32'(e*4), 1'b0, 32'h0, 4'h0, 1'b1);
            n_checks++; if (busy !== 1'b1 || gnt !== 2'(e) || req_o !== rexp) $display("FAIL fair_grant%0d: got busy %0b gnt %0d req %h want 1 %0d %h", n, busy, gnt, req_o, e, rexp); else n_pass++;
            rsp_i = mk_rsp(32'hA000 + 32'(n), (n == 2), 1'b1);
            #1;
            er = '0;
            er[e*RSW +: RSW] = mk_rsp(32'hA000 + 32'(n), (n == 2), 1'b1);
            n_checks++; if (rsp_o !== er) $display("FAIL fair_rsp%0d: got %h want %h", n, rsp_o, er); else n_pass++;
            tick();
            rsp_i = '0;
            #1;
            n_checks++; if (busy !== 1'b0) $display("FAIL fair_bubble%0d: got %0b want 0", n, busy); else n_pass++;
        end
        req_i = '0;
    endtask

    task automatic test_stability;
        logic [RQW-1:0]    r, r2;
        logic [NR*RSW-1:0] er;
        r  = mk_req(32'h400, 1'b1, 32'h1234, 4'h3, 1'b1);
        r2 = mk_req(32'h500, 1'b0, 32'h0, 4'h0, 1'b1);
        set_req(1, r);
        tick();
        n_checks++; if (gnt !== 2'd1 || req_o !== r) $display("FAIL st_grant: got gnt %0d req %h want 1 %h", gnt, req_o, r); else n_pass++;
        for (int i = 0; i < STALL; i++) begin
            set_req(1, mk_req(32'h400, 1'b1, 32'h5555_0000 + 32'(i), 4'h3, 1'b1));
            set_req(2, r2);
            tick();
            n_checks++; if (req_o !== r || gnt !== 2'd1) $display("FAIL st_hold%0d: got gnt %0d req %h want 1 %h", i, gnt, req_o, r); else n_pass++;
        end
        rsp_i = mk_rsp(32'h0, 1'b0, 1'b1);
        #1;
        er = '0;
        er[1*RSW +: RSW] = mk_rsp(32'h0, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL st_rsp: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(1, '0);
        rsp_i = '0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL st_bubble: got %0b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'd2 || req_o !== r2) $display("FAIL st_waiter: got gnt %0d req %h want 2 %h", gnt, req_o, r2); else n_pass++;
        rsp_i = mk_rsp(32'h0, 1'b0, 1'b1);
        tick();
        set_req(2, '0);
        rsp_i = '0;
    endtask

    task automatic test_reset_mid_busy;
        logic [RQW-1:0] r0;
        set_req(3, mk_req(32'h600, 1'b1, 32'h77, 4'h1, 1'b1));
        tick();
        n_checks++; if (busy !== 1'b1 || gnt !== 2'd3) $display("FAIL rm_busy: got %0b/%0d want 1/3", busy, gnt); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || req_o !== '0) $display("FAIL rm_async: got busy %0b req %h want 0 0", busy, req_o); else n_pass++;
        n_checks++; if (rsp_o !== '0 || gnt !== 2'd0) $display("FAIL rm_outs: got rsp %h gnt %0d want 0 0", rsp_o, gnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        r0 = mk_req(32'h700, 1'b0, 32'h0, 4'h0, 1'b1);
        set_req(0, r0);
        set_req(3, mk_req(32'h800, 1'b0, 32'h0, 4'h0, 1'b1));
        tick();
        n_checks++; if (gnt !== 2'd0 || req_o !== r0) $display("FAIL rm_ptr: got gnt %0d req %h want 0 %h", gnt, req_o, r0); else n_pass++;
        rsp_i = mk_rsp(32'h0, 1'b0, 1'b1);
        tick();
        req_i = '0;
        rsp_i = '0;
    endtask

`ifdef DMA_REG_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [RQW-1:0]    r;
        logic [NR*RSW-1:0] er;
        r = mk_req(32'h900, 1'b0, 32'h0, 4'h0, 1'b1);
        set_req(1, r);
        tick();
        for (int c = 1; c < 8; c++) begin
            n_checks++; if (rsp_o !== '0) $display("FAIL to_wait%0d: got %h want 0", c, rsp_o); else n_pass++;
            tick();
        end
        er = '0;
        er[1*RSW +: RSW] = mk_rsp(32'h0, 1'b1, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL to_abort: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(1, '0);
        set_req(2, mk_req(32'hA00, 1'b0, 32'h0, 4'h0, 1'b1));
        for (int c = 9; c < 20; c++) begin
            n_checks++; if (busy !== 1'b1 || req_o !== r || rsp_o !== '0) $display("FAIL to_drain%0d: got busy %0b req %h rsp %h", c, busy, req_o, rsp_o); else n_pass++;
            tick();
        end
        rsp_i = mk_rsp(32'hBAD, 1'b0, 1'b1);
        #1;
        n_checks++; if (rsp_o !== '0) $display("FAIL to_discard: got %h want 0", rsp_o); else n_pass++;
        tick();
        rsp_i = '0;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_idle: got %0b want 0", busy); else n_pass++;
        tick();
        n_checks++; if (gnt !== 2'd2 || busy !== 1'b1) $display("FAIL to_next: got gnt %0d busy %0b want 2 1", gnt, busy); else n_pass++;
        for (int c = 1; c < 7; c++) tick();
        rsp_i = mk_rsp(32'h77, 1'b0, 1'b1);
        #1;
        er = '0;
        er[2*RSW +: RSW] = mk_rsp(32'h77, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL to_c7: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(2, '0);
        rsp_i = '0;
        set_req(3, mk_req(32'hB00, 1'b0, 32'h0, 4'h0, 1'b1));
        tick();
        for (int c = 1; c < 8; c++) tick();
        rsp_i = mk_rsp(32'h88, 1'b0, 1'b1);
        #1;
        er = '0;
        er[3*RSW +: RSW] = mk_rsp(32'h88, 1'b0, 1'b1);
        n_checks++; if (rsp_o !== er) $display("FAIL to_c8_tie: got %h want %h", rsp_o, er); else n_pass++;
        tick();
        set_req(3, '0);
        rsp_i = '0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_tie_idle: got %0b want 0", busy); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_fairness();
        test_stability();
        test_reset_mid_busy();
`ifdef DMA_REG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
